// File: rtl/render_scheduler.sv
// render_scheduler: decides when the register-dump renderer redraws a frame,
// re-arms it through its reset, stalls the CPU meanwhile and shares the ASCII port.
module render_scheduler #(
  parameter int REFRESH_CYCLES = 833333,
  parameter int TIMEOUT_CYCLES = 16383,
  parameter int ARM_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        step_evt,
  input  logic        force_refresh,
  output logic        rnd_rst_n,
  output logic        rnd_start,
  input  logic        rnd_done,
  input  logic        rnd_we,
  input  logic [31:0] rnd_data,
  input  logic [12:0] rnd_addr,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_data,
  input  logic [12:0] host_addr,
  output logic        host_gnt,
  output logic        ascii_write_en,
  output logic [31:0] ascii_input,
  output logic [12:0] ascii_write_address,
  output logic        cpu_hold,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] frame_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam int CW = $clog2(TIMEOUT_CYCLES + ARM_CYCLES + 1);
  localparam logic [CW-1:0] ARM_LAST = CW'(ARM_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RF_LAST = 32'(REFRESH_CYCLES - 1);
  localparam bit RF_ON = (REFRESH_CYCLES != 0);

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   rf_timer;
  logic          pending;
  logic          live;
  logic          rf_hit;
  logic          evt;
  logic          busy_st;
  logic          idle_go;
  logic          done_ok;
  logic          tmo_hit;

  assign busy_st = (state != S_IDLE);
  assign rf_hit  = RF_ON && enable && (rf_timer == RF_LAST);
  assign evt     = enable && (step_evt || force_refresh || rf_hit);
  assign idle_go = !host_req && pending && enable;
  // A done level left over from the previous frame is ignored on RUN's first cycle
  assign done_ok = rnd_done && (cnt != '0);
  assign tmo_hit = (cnt == TMO_LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (idle_go) state_n = S_ARM;
      S_ARM:   if (cnt == ARM_LAST) state_n = S_START;
      S_START: state_n = S_RUN;
      S_RUN:   if (done_ok || tmo_hit) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rf_timer    <= '0;
      pending     <= 1'b0;
      live        <= 1'b0;
      frame_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      live  <= 1'b1;
      state <= state_n;
      if (state_n != state || state == S_IDLE) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (!enable || rf_hit) rf_timer <= '0;
      else if (RF_ON) rf_timer <= rf_timer + 32'd1;
      // A new event wins over the clear, so it is never lost
      if (evt) pending <= 1'b1;
      else if (state == S_IDLE && state_n == S_ARM) pending <= 1'b0;
      if (state == S_RUN && done_ok) frame_count <= frame_count + 16'd1;
      if (state == S_RUN && !done_ok && tmo_hit) timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ascii_write_en      <= 1'b0;
      ascii_input         <= '0;
      ascii_write_address <= '0;
    end else if (busy_st) begin
      ascii_write_en      <= rnd_we;
      ascii_input         <= rnd_data;
      ascii_write_address <= rnd_addr;
    end else if (host_gnt) begin
      ascii_write_en      <= host_we;
      ascii_input         <= host_data;
      ascii_write_address <= host_addr;
    end else begin
      ascii_write_en <= 1'b0;
    end
  end

  assign rnd_rst_n = live && (state != S_ARM);
  assign rnd_start = (state == S_START);
  assign host_gnt  = live && (state == S_IDLE) && host_req;
  assign busy      = busy_st;
  assign cpu_hold  = busy_st;

endmodule
